lcd_bus_sequencer: RTL and testbench
====================================

# lcd_bus_sequencer

Parametrised 8080-style parallel write engine for the HX8352-class TFT panel, superseding the fixed 16-bit controller wiring. Accepts a stream of typed entries (command, data, delay, fill) through a valid/ready port into an internal FIFO and plays them onto the LCD bus with configurable WR strobe timing, 8- or 16-bit bus width, and a built-in panel hardware-reset sequence. Sits between the pixel/init generators and the board LCD pins; status outputs feed the TM1638 debug display.

## Interface
- BUS_W, 16, LCD data bus width; legal values 8 or 16
- FIFO_DEPTH, 16, entry FIFO depth; power of two, ≥2
- WR_LOW_CYC, 2, clk cycles WR held low per beat; ≥1
- WR_HIGH_CYC, 2, clk cycles WR held high after each beat; ≥1
- DELAY_PRESCALE, 50, clk cycles per delay unit; ≥1
- RST_CYC, 500, cycles lcd_rst held low, and cycles waited after release
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  entry present
- in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready
- in_kind  in  2  00 command, 01 data, 10 delay, 11 fill
- in_payload  in  16  command/data word, delay units, or fill count
- lcd_cs, lcd_rs, lcd_wr, lcd_rd, lcd_rst  out  1 each  panel control, all active-low except rs (1 = data)
- lcd_data  out  BUS_W  panel data bus
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- busy  out  1  high unless state IDLE and FIFO empty

## Operation
- States: RST_LOW, RST_WAIT, IDLE, SETUP, WR_LOW, WR_HIGH, DELAY.
- After rst: RST_LOW (lcd_rst=0) RST_CYC cycles, then RST_WAIT (lcd_rst=1) RST_CYC cycles, then IDLE. FIFO accepts entries during both; they are held.
- IDLE with FIFO non-empty: pop one entry into current registers, go to SETUP (command/data/fill), DELAY, or stay IDLE for zero-length ops.
- SETUP (1 cycle): lcd_cs=0, lcd_rs and lcd_data driven, lcd_wr=1. WR_LOW: lcd_wr=0 for WR_LOW_CYC. WR_HIGH: lcd_wr=1 for WR_HIGH_CYC, data/rs held (panel latches on rising WR).
- Command: rs=0, one beat of payload[BUS_W-1:0]. Data: rs=1; BUS_W=16 one beat; BUS_W=8 two beats, payload[15:8] then [7:0], second beat goes WR_HIGH→SETUP directly.
- Every data entry updates a last-data register (reset 16'h0000).
- Delay: DELAY holds bus idle (cs=1) for payload×DELAY_PRESCALE cycles; payload 0 returns to IDLE with no DELAY cycle.
- Fill: see Configuration. Fill count 0 produces no beats.
- After final beat of an entry, return to IDLE; lcd_cs=1 in IDLE, DELAY, RST_*.
- lcd_rd constant 1 (write-only engine).
- FIFO full: in_ready=0; push blocked regardless of same-cycle pop. Empty: no pop.
- rst mid-operation: abort current beat, flush FIFO, restart reset sequence; no partial beat completes.

## Timing
- Reset values: lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=1, lcd_data=0, lcd_rst=0, in_ready=1, fifo_level=0, busy=1.
- All outputs registered.
- Beat cost: 1+WR_LOW_CYC+WR_HIGH_CYC cycles; entry cost adds 1 IDLE pop cycle. Defaults, BUS_W=16: 6 cycles/entry; BUS_W=8 data: 11.
- Accepted entry visible in fifo_level next cycle; earliest SETUP 2 cycles after acceptance into an empty FIFO in IDLE.

## Configuration
- LCD_BUS_FILL_EN defined: kind 11 repeats the last-data word payload times as data beats, no FIFO pops between repeats; 16-bit repeat counter.
- Undefined: kind 11 is popped and discarded (1 IDLE cycle, no bus activity); repeat counter not synthesised.

## Structure
- Package lcd_bus_pkg: kind encodings (KIND_CMD, KIND_DATA, KIND_DELAY, KIND_FILL), state enum.
- Sub-module lcd_bus_fifo: synchronous FIFO, parametrised width (18) and depth, with level output.

## Test plan
- Reset release, defaults -> lcd_rst low exactly 500 cycles, high 500 more, then IDLE; busy falls with empty FIFO.
- BUS_W=16, command 16'h0022 then data 16'hF800 -> rs 0 then 1, WR low 2 cycles each, entries 6 cycles apart, lcd_data matches.
- BUS_W=8, data 16'hABCD -> two beats 8'hAB then 8'hCD, rs=1, cs low throughout.
- Push 17 entries into depth-16 FIFO while in RST_LOW -> in_ready drops after 16, 17th held until a pop, fifo_level=16.
- Data 16'h07E0 then fill 3 (FILL_EN) -> 4 total beats of 16'h07E0; without macro -> 1 beat; delay 2 -> 100 idle cycles with cs=1.
- Assert rst during WR_LOW -> next cycle lcd_wr=1, lcd_cs=1, lcd_rst=0, fifo_level=0.

Source files
------------

// File: rtl/lcd_bus_pkg.sv
// Shared encodings for the LCD bus sequencer: entry kinds, FIFO entry width, FSM states.
package lcd_bus_pkg;

    localparam logic [1:0] KIND_CMD   = 2'b00;
    localparam logic [1:0] KIND_DATA  = 2'b01;
    localparam logic [1:0] KIND_DELAY = 2'b10;
    localparam logic [1:0] KIND_FILL  = 2'b11;

    localparam int unsigned ENTRY_W = 18;

    typedef enum logic [2:0] {
        ST_RST_LOW,
        ST_RST_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_WR_LOW,
        ST_WR_HIGH,
        ST_DELAY
    } state_t;

endpackage

// File: rtl/lcd_bus_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy and its next value.
module lcd_bus_fifo
    import lcd_bus_pkg::*;
#(
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] level_nxt_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, do_push, do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign level_nxt_o = level_d;

endmodule

// File: rtl/lcd_bus_sequencer.sv
// 8080-style LCD write engine: entry FIFO, panel reset sequence, WR strobe timing.
// Define LCD_BUS_FILL_EN to enable fill entries (repeat last data word).
module lcd_bus_sequencer
    import lcd_bus_pkg::*;
#(
    parameter int unsigned BUS_W          = 16,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned WR_LOW_CYC     = 2,
    parameter int unsigned WR_HIGH_CYC    = 2,
    parameter int unsigned DELAY_PRESCALE = 50,
    parameter int unsigned RST_CYC        = 500,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [15:0]      in_payload,
    output logic             lcd_cs,
    output logic             lcd_rs,
    output logic             lcd_wr,
    output logic             lcd_rd,
    output logic             lcd_rst,
    output logic [BUS_W-1:0] lcd_data,
    output logic [LVL_W-1:0] fifo_level,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [15:0]        word_q, word_d;
    logic               data_q, data_d;
    logic               lo_q, lo_d;
`ifdef LCD_BUS_FILL_EN
    logic [15:0]        last_q, last_d;
    logic [15:0]        rep_q, rep_d;
`endif

    logic               lcd_cs_q, lcd_cs_d, lcd_rs_q, lcd_rs_d;
    logic               lcd_wr_q, lcd_wr_d, lcd_rst_q, lcd_rst_d;
    logic [BUS_W-1:0]   lcd_data_q, lcd_data_d;
    logic               in_ready_q, in_ready_d, busy_q, busy_d;
    logic [15:0]        beat_w;

    logic               pop, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic [LVL_W-1:0]   level_nxt;
    logic [1:0]         e_kind;
    logic [15:0]        e_pay;

    assign e_kind = fifo_rdata[17:16];
    assign e_pay  = fifo_rdata[15:0];

    lcd_bus_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in_valid & in_ready_q),
        .pop_i       (pop),
        .wdata_i     ({in_kind, in_payload}),
        .rdata_o     (fifo_rdata),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .level_nxt_o (level_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RST_LOW;
            cnt_q      <= RST_CYC - 1;
            word_q     <= '0;
            data_q     <= 1'b0;
            lo_q       <= 1'b0;
`ifdef LCD_BUS_FILL_EN
            last_q     <= '0;
            rep_q      <= '0;
`endif
            lcd_cs_q   <= 1'b1;
            lcd_rs_q   <= 1'b1;
            lcd_wr_q   <= 1'b1;
            lcd_rst_q  <= 1'b0;
            lcd_data_q <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            data_q     <= data_d;
            lo_q       <= lo_d;
`ifdef LCD_BUS_FILL_EN
            last_q     <= last_d;
            rep_q      <= rep_d;
`endif
            lcd_cs_q   <= lcd_cs_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_wr_q   <= lcd_wr_d;
            lcd_rst_q  <= lcd_rst_d;
            lcd_data_q <= lcd_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        data_d  = data_q;
        lo_d    = lo_q;
        pop     = 1'b0;
`ifdef LCD_BUS_FILL_EN
        last_d  = last_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            ST_RST_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_RST_WAIT;
                    cnt_d   = RST_CYC - 1;
                end else cnt_d = cnt_q - 32'd1;
            end
            ST_RST_WAIT: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 32'd1;
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    lo_d = 1'b0;
                    case (e_kind)
                        KIND_CMD: begin
                            state_d = ST_SETUP;
                            word_d  = e_pay;
                            data_d  = 1'b0;
                        end
                        KIND_DATA: begin
                            state_d = ST_SETUP;
                            word_d  = e_pay;
                            data_d  = 1'b1;
`ifdef LCD_BUS_FILL_EN
                            last_d  = e_pay;
`endif
                        end
                        KIND_DELAY: begin
                            if (e_pay != '0) begin
                                state_d = ST_DELAY;
                                cnt_d   = 32'(e_pay) * 32'(DELAY_PRESCALE) - 32'd1;
                            end
                        end
                        KIND_FILL: begin
`ifdef LCD_BUS_FILL_EN
                            if (e_pay != '0) begin
                                state_d = ST_SETUP;
                                word_d  = last_q;
                                data_d  = 1'b1;
                                rep_d   = e_pay - 16'd1;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_SETUP: begin
                state_d = ST_WR_LOW;
                cnt_d   = WR_LOW_CYC - 1;
            end
            ST_WR_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HIGH;
                    cnt_d   = WR_HIGH_CYC - 1;
                end else cnt_d = cnt_q - 32'd1;
            end
            ST_WR_HIGH: begin
                // Second byte and fill repeats re-enter SETUP without an IDLE pop cycle
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (BUS_W == 8 && data_q && !lo_q) begin
                    lo_d    = 1'b1;
                    state_d = ST_SETUP;
                end
`ifdef LCD_BUS_FILL_EN
                else if (rep_q != '0) begin
                    rep_d   = rep_q - 16'd1;
                    lo_d    = 1'b0;
                    state_d = ST_SETUP;
                end
`endif
                else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = ST_RST_LOW;
        endcase
    end

    always_comb begin
        if (BUS_W == 8) beat_w = (data_d && !lo_d) ? {8'h00, word_d[15:8]} : {8'h00, word_d[7:0]};
        else            beat_w = word_d;
        lcd_cs_d   = !(state_d inside {ST_SETUP, ST_WR_LOW, ST_WR_HIGH});
        lcd_wr_d   = (state_d != ST_WR_LOW);
        lcd_rst_d  = (state_d != ST_RST_LOW);
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        if (state_d == ST_SETUP) begin
            lcd_rs_d   = data_d;
            lcd_data_d = beat_w[BUS_W-1:0];
        end
        in_ready_d = (level_nxt != LVL_W'(FIFO_DEPTH));
        busy_d     = !(state_d == ST_IDLE && level_nxt == '0);
    end

    assign lcd_cs   = lcd_cs_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_wr   = lcd_wr_q;
    assign lcd_rd   = 1'b1;
    assign lcd_rst  = lcd_rst_q;
    assign lcd_data = lcd_data_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench: a default 16-bit instance and an 8-bit instance with a short reset sequence.
module tb_lcd_bus_sequencer;

    typedef struct {
        int          start;
        int          low;
        logic        rs;
        logic [15:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    logic        a_rst, a_valid, a_ready, a_cs, a_rs, a_wr, a_rd, a_lrst, a_busy;
    logic [1:0]  a_kind;
    logic [15:0] a_pay, a_data;
    logic [4:0]  a_level;

    logic        b_rst, b_valid, b_ready, b_cs, b_rs, b_wr, b_rd, b_lrst, b_busy;
    logic [1:0]  b_kind;
    logic [15:0] b_pay;
    logic [7:0]  b_data;
    logic [4:0]  b_level;

    lcd_bus_sequencer u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_kind(a_kind), .in_payload(a_pay),
        .lcd_cs(a_cs), .lcd_rs(a_rs), .lcd_wr(a_wr), .lcd_rd(a_rd), .lcd_rst(a_lrst),
        .lcd_data(a_data), .fifo_level(a_level), .busy(a_busy)
    );

    lcd_bus_sequencer #(.BUS_W(8), .RST_CYC(4)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_kind(b_kind), .in_payload(b_pay),
        .lcd_cs(b_cs), .lcd_rs(b_rs), .lcd_wr(b_wr), .lcd_rd(b_rd), .lcd_rst(b_lrst),
        .lcd_data(b_data), .fifo_level(b_level), .busy(b_busy)
    );

    // Beat monitors: a beat is logged when WR rises, with WR-low length and start cycle
    beat_t qa[$], qb[$];
    logic a_pwr = 1'b1, b_pwr = 1'b1;
    int   a_st, a_lo, b_st, b_lo, b_cslow;

    always @(negedge clk) begin
        if (!a_wr) begin
            if (a_pwr) begin a_st = cyc; a_lo = 0; end
            a_lo++;
        end else if (!a_pwr) qa.push_back('{a_st, a_lo, a_rs, a_data});
        a_pwr = a_wr;
        if (!b_wr) begin
            if (b_pwr) begin b_st = cyc; b_lo = 0; end
            b_lo++;
        end else if (!b_pwr) qb.push_back('{b_st, b_lo, b_rs, {8'h00, b_data}});
        b_pwr = b_wr;
        if (!b_cs) b_cslow++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drv_a(input logic [1:0] k, input logic [15:0] p);
        a_valid = 1'b1; a_kind = k; a_pay = p;
        @(negedge clk);
    endtask

    task automatic drv_b(input logic [1:0] k, input logic [15:0] p);
        b_valid = 1'b1; b_kind = k; b_pay = p;
        @(negedge clk);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (a_busy && n < 500) begin @(negedge clk); n++; end
        check("idle_a", a_busy, 0);
    endtask

    task automatic wait_idle_b();
        int n = 0;
        while (b_busy && n < 500) begin @(negedge clk); n++; end
        check("idle_b", b_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, t0, r, nexp;
        a_rst = 1'b1; a_valid = 1'b0; a_kind = 2'b00; a_pay = '0;
        b_rst = 1'b1; b_valid = 1'b0; b_kind = 2'b00; b_pay = '0;
        repeat (3) @(negedge clk);

        check("rst_cs", a_cs, 1);
        check("rst_wr", a_wr, 1);
        check("rst_rd", a_rd, 1);
        check("rst_rs", a_rs, 1);
        check("rst_data", a_data, 0);
        check("rst_lcdrst", a_lrst, 0);
        check("rst_ready", a_ready, 1);
        check("rst_level", a_level, 0);
        check("rst_busy", a_busy, 1);

        a_rst = 1'b0; b_rst = 1'b0;
        n = 0;
        while (a_lrst == 1'b0 && n < 2000) begin n++; @(negedge clk); end
        check("rst_low_cycles", n, 500);
        n = 0;
        while (a_lrst == 1'b1 && a_busy && n < 2000) begin n++; @(negedge clk); end
        check("rst_wait_cycles", n, 500);
        check("busy_after_rst", a_busy, 0);

        // command then data, 16-bit bus
        qa.delete();
        t0 = cyc;
        drv_a(2'b00, 16'h0022);
        drv_a(2'b01, 16'hF800);
        a_valid = 1'b0;
        wait_idle_a();
        check("cd_beats", qa.size(), 2);
        if (qa.size() >= 2) begin
            check("cd_latency", qa[0].start - t0, 3);
            check("cmd_rs", qa[0].rs, 0);
            check("cmd_data", qa[0].data, 16'h0022);
            check("cmd_wrlow", qa[0].low, 2);
            check("dat_rs", qa[1].rs, 1);
            check("dat_data", qa[1].data, 16'hF800);
            check("dat_wrlow", qa[1].low, 2);
            check("entry_spacing", qa[1].start - qa[0].start, 6);
        end

        // data then fill 3
        qa.delete();
        drv_a(2'b01, 16'h07E0);
        drv_a(2'b11, 16'd3);
        a_valid = 1'b0;
        wait_idle_a();
`ifdef LCD_BUS_FILL_EN
        nexp = 4;
`else
        nexp = 1;
`endif
        check("fill_beats", qa.size(), nexp);
        foreach (qa[i]) begin
            check("fill_data", qa[i].data, 16'h07E0);
            check("fill_rs", qa[i].rs, 1);
        end
        if (qa.size() > 0)
            check("fill_span", qa[qa.size()-1].start - qa[0].start, (nexp == 4) ? 16 : 0);

        // delay 2 units then a command
        qa.delete();
        t0 = cyc;
        drv_a(2'b10, 16'd2);
        drv_a(2'b00, 16'h002C);
        a_valid = 1'b0;
        while (cyc < t0 + 50) @(negedge clk);
        check("delay_cs", a_cs, 1);
        check("delay_wr", a_wr, 1);
        check("delay_busy", a_busy, 1);
        wait_idle_a();
        check("delay_beats", qa.size(), 1);
        if (qa.size() >= 1) check("delay_latency", qa[0].start - t0, 104);

        // reset asserted during WR low
        drv_a(2'b00, 16'h0001);
        drv_a(2'b00, 16'h0002);
        drv_a(2'b00, 16'h0003);
        a_valid = 1'b0;
        n = 0;
        while (a_wr && n < 50) begin @(negedge clk); n++; end
        check("wr_low_seen", a_wr, 0);
        a_rst = 1'b1;
        @(negedge clk);
        check("abort_wr", a_wr, 1);
        check("abort_cs", a_cs, 1);
        check("abort_lcdrst", a_lrst, 0);
        check("abort_level", a_level, 0);
        a_rst = 1'b0;
        r = cyc;

        // 17 entries into a 16-deep FIFO during RST_LOW
        for (int i = 0; i < 16; i++) drv_a(2'b10, 16'd0);
        check("full_ready", a_ready, 0);
        check("full_level", a_level, 16);
        repeat (5) @(negedge clk);
        check("held_ready", a_ready, 0);
        check("held_level", a_level, 16);
        check("held_lcdrst", a_lrst, 0);
        n = 0;
        while (!a_ready && n < 3000) begin @(negedge clk); n++; end
        check("held_wait", n, 980);
        check("first_pop_cycle", cyc - r, 1001);
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle_a();
        check("drain_level", a_level, 0);

        // 8-bit bus: data splits into two beats with CS held low
        check("b_idle", b_busy, 0);
        qb.delete();
        b_cslow = 0;
        t0 = cyc;
        drv_b(2'b01, 16'hABCD);
        b_valid = 1'b0;
        wait_idle_b();
        check("b8_beats", qb.size(), 2);
        if (qb.size() >= 2) begin
            check("b8_latency", qb[0].start - t0, 3);
            check("b8_hi", qb[0].data, 16'h00AB);
            check("b8_lo", qb[1].data, 16'h00CD);
            check("b8_rs0", qb[0].rs, 1);
            check("b8_rs1", qb[1].rs, 1);
            check("b8_spacing", qb[1].start - qb[0].start, 5);
        end
        check("b8_cs_low", b_cslow, 10);

        qb.delete();
        drv_b(2'b00, 16'h1234);
        b_valid = 1'b0;
        wait_idle_b();
        check("b8_cmd_beats", qb.size(), 1);
        if (qb.size() >= 1) begin
            check("b8_cmd_data", qb[0].data, 16'h0034);
            check("b8_cmd_rs", qb[0].rs, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
